seq_detector_counter: RTL and testbench

Parametrised serial sequence detector with a match counter, generalising the fixed Moore/Mealy detectors on the board top. It samples one serial bit per enable strobe and compares a W-bit history window against a runtime-loadable pattern with a don't-care mask. Overlapping or non-overlapping detection is selectable at run time. It produces Mealy and Moore match outputs plus a wrapping or saturating hit counter with a sticky overflow flag, feeding the seven-segment display mux.

---
 rtl/seq_detector_counter.sv | 135 +++++++++++++
 tb/tb_seq_detector_counter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detector_counter.sv
`default_nettype none
// ============================================================================
// Module      : seq_detector_counter
// Description : Serial sequence detector with a runtime-loadable pattern and
//               don't-care mask, selectable overlapping/non-overlapping
//               detection, Mealy and Moore match outputs, and a wrapping or
//               saturating hit counter with a sticky overflow flag.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   W            : pattern / window width in bits (2..16)
//   CNT_W        : hit counter width
//   SATURATE     : 0 = counter wraps to 0 after max, 1 = counter holds at max
//   PATTERN_INIT : pattern register value after reset
// Ports
//   clk        in   1      system clock, rising edge
//   reset      in   1      synchronous active-high reset
//   en         in   1      sample strobe, one bit consumed per en cycle
//   a          in   1      serial data bit, valid when en=1
//   overlap    in   1      1 = overlapping detection, 0 = restart after match
//   load       in   1      latch pattern_in/mask_in and restart history
//   pattern_in in   W      new pattern (bit W-1 oldest, bit 0 newest)
//   mask_in    in   W      1 = compare bit, 0 = don't care
//   clear      in   1      zero counter/overflow and restart history
//   y_mealy    out  1      combinational match including current a
//   y_moore    out  1      registered match, held between en cycles
//   hit_cnt    out  CNT_W  number of matches
//   overflow   out  1      sticky, set on a match with hit_cnt all-ones
// ============================================================================
module seq_detector_counter #(
  parameter int             W            = 4,
  parameter int             CNT_W        = 8,
  parameter int             SATURATE     = 0,
  parameter logic [W-1:0]   PATTERN_INIT = W'(4'b1011)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             a,
  input  logic             overlap,
  input  logic             load,
  input  logic [W-1:0]     pattern_in,
  input  logic [W-1:0]     mask_in,
  input  logic             clear,
  output logic             y_mealy,
  output logic             y_moore,
  output logic [CNT_W-1:0] hit_cnt,
  output logic             overflow
);

  // The fill counter only needs to reach W, so it is sized for 0..W.
  localparam int          c_FILL_W = $clog2(W + 1);
  localparam logic [c_FILL_W-1:0] c_FILL_FULL = c_FILL_W'(W);
  localparam logic [c_FILL_W-1:0] c_FILL_READY = c_FILL_W'(W - 1);
  localparam bit          c_WRAP = (SATURATE == 0);

  // Only the W-1 most recent bits are kept; the newest bit of the window is
  // always the live input a.
  logic [W-2:0]          r_hist;
  logic [c_FILL_W-1:0]   r_fill;
  logic [W-1:0]          r_pattern;
  logic [W-1:0]          r_mask;
  logic                  r_y_moore;
  logic [CNT_W-1:0]      r_hit_cnt;
  logic                  r_overflow;

  logic [W-1:0]          w_win;
  logic                  w_ctl;
  logic                  w_filled;
  logic                  w_cmp_ok;
  logic                  w_match;
  logic                  w_cnt_at_max;

  assign w_win        = {r_hist, a};
  assign w_ctl        = load | clear;
  assign w_filled     = (r_fill >= c_FILL_READY);
  assign w_cmp_ok     = (((w_win ^ r_pattern) & r_mask) == '0);
  // load/clear take priority over sampling, and reset suppresses the
  // combinational output as well so nothing is flagged in a reset cycle.
  assign w_match      = en & ~w_ctl & ~reset & w_filled & w_cmp_ok;
  assign w_cnt_at_max = &r_hit_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hist     <= '0;
      r_fill     <= '0;
      r_pattern  <= PATTERN_INIT;
      r_mask     <= '1;
      r_y_moore  <= 1'b0;
      r_hit_cnt  <= '0;
      r_overflow <= 1'b0;
    end else if (w_ctl) begin
      // Both controls restart the history; en is ignored this cycle.
      r_fill    <= '0;
      r_y_moore <= 1'b0;
      if (load) begin
        r_pattern <= pattern_in;
        r_mask    <= mask_in;
      end
      if (clear) begin
        r_hit_cnt  <= '0;
        r_overflow <= 1'b0;
      end
    end else if (en) begin
      r_hist    <= w_win[W-2:0];
      r_y_moore <= w_match;

      // Non-overlapping mode discards the bits that formed the match; the
      // stale history contents are masked out by the fill count.
      if (w_match && !overlap) begin
        r_fill <= '0;
      end else if (r_fill < c_FILL_FULL) begin
        r_fill <= r_fill + c_FILL_W'(1);
      end

      if (w_match) begin
        if (w_cnt_at_max) begin
          r_overflow <= 1'b1;
          if (c_WRAP) begin
            r_hit_cnt <= '0;
          end
        end else begin
          r_hit_cnt <= r_hit_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign y_mealy  = w_match;
  assign y_moore  = r_y_moore;
  assign hit_cnt  = r_hit_cnt;
  assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_seq_detector_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_detector_counter
// Description : Randomised and directed bench for seq_detector_counter. Three
//               instances share one stimulus stream: an 8-bit counter, a
//               2-bit wrapping counter and a 2-bit saturating counter. The
//               reference model keeps the accepted bits as a queue and
//               counts matches with plain integers.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_detector_counter;

  localparam int W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset = 1'b1;
  logic         en = 1'b0;
  logic         a = 1'b0;
  logic         overlap = 1'b0;
  logic         load = 1'b0;
  logic         clear = 1'b0;
  logic [W-1:0] pattern_in = '0;
  logic [W-1:0] mask_in = '0;

  logic         ym [3];
  logic         yo [3];
  logic         ov [3];
  logic [7:0]   hc0;
  logic [1:0]   hc1;
  logic [1:0]   hc2;

  seq_detector_counter #(.W(W), .CNT_W(8), .SATURATE(0), .PATTERN_INIT(4'b1011)) u_dut (
    .clk(clk), .reset(reset), .en(en), .a(a), .overlap(overlap), .load(load),
    .pattern_in(pattern_in), .mask_in(mask_in), .clear(clear),
    .y_mealy(ym[0]), .y_moore(yo[0]), .hit_cnt(hc0), .overflow(ov[0])
  );

  seq_detector_counter #(.W(W), .CNT_W(2), .SATURATE(0), .PATTERN_INIT(4'b1011)) u_wrap (
    .clk(clk), .reset(reset), .en(en), .a(a), .overlap(overlap), .load(load),
    .pattern_in(pattern_in), .mask_in(mask_in), .clear(clear),
    .y_mealy(ym[1]), .y_moore(yo[1]), .hit_cnt(hc1), .overflow(ov[1])
  );

  seq_detector_counter #(.W(W), .CNT_W(2), .SATURATE(1), .PATTERN_INIT(4'b1011)) u_sat (
    .clk(clk), .reset(reset), .en(en), .a(a), .overlap(overlap), .load(load),
    .pattern_in(pattern_in), .mask_in(mask_in), .clear(clear),
    .y_mealy(ym[2]), .y_moore(yo[2]), .hit_cnt(hc2), .overflow(ov[2])
  );

  // ---------------- reference model ----------------
  bit           q[$];          // bits accepted since the last restart
  logic [W-1:0] m_pat;
  logic [W-1:0] m_msk;
  bit           m_moore;
  int           m_cnt [3];
  bit           m_ovf [3];
  int           m_max [3] = '{255, 3, 3};
  bit           m_sat [3] = '{1'b0, 1'b0, 1'b1};

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    m_pat   = 4'b1011;
    m_msk   = 4'b1111;
    m_moore = 1'b0;
    for (int k = 0; k < 3; k++) begin
      m_cnt[k] = 0;
      m_ovf[k] = 1'b0;
    end
  endfunction

  // A match needs W accepted bits: the last W-1 in the queue plus live a.
  function automatic bit model_match(input bit e, input bit b, input bit blocked);
    logic [W-1:0] win;
    int n;
    if (!e || blocked) return 1'b0;
    n = q.size();
    if (n < W - 1) return 1'b0;
    win = '0;
    for (int i = n - (W - 1); i < n; i++) win = {win[W-2:0], q[i]};
    win = {win[W-2:0], b};
    return (((win ^ m_pat) & m_msk) == '0);
  endfunction

  task automatic step(input bit e, input bit b, input bit ovl, input bit ld, input bit cl,
                      input bit rs, input logic [W-1:0] pi, input logic [W-1:0] mi);
    bit m;
    logic [31:0] got_cnt [3];
    @(negedge clk);
    en = e; a = b; overlap = ovl; load = ld; clear = cl; reset = rs;
    pattern_in = pi; mask_in = mi;
    #1;
    m = model_match(e, b, ld | cl | rs);
    got_cnt[0] = 32'(hc0);
    got_cnt[1] = 32'(hc1);
    got_cnt[2] = 32'(hc2);
    for (int k = 0; k < 3; k++) begin
      check_value($sformatf("mealy[%0d]", k), 32'(ym[k]), 32'(m));
      check_value($sformatf("moore[%0d]", k), 32'(yo[k]), 32'(m_moore));
      check_value($sformatf("cnt[%0d]", k), got_cnt[k], 32'(m_cnt[k]));
      check_value($sformatf("ovf[%0d]", k), 32'(ov[k]), 32'(m_ovf[k]));
    end
    @(posedge clk);
    if (rs) begin
      model_reset();
    end else if (ld || cl) begin
      q.delete();
      m_moore = 1'b0;
      if (ld) begin
        m_pat = pi;
        m_msk = mi;
      end
      if (cl) begin
        for (int k = 0; k < 3; k++) begin
          m_cnt[k] = 0;
          m_ovf[k] = 1'b0;
        end
      end
    end else if (e) begin
      m_moore = m;
      q.push_back(b);
      if (q.size() > W) void'(q.pop_front());
      if (m) begin
        if (!ovl) q.delete();
        for (int k = 0; k < 3; k++) begin
          if (m_cnt[k] == m_max[k]) begin
            m_ovf[k] = 1'b1;
            if (!m_sat[k]) m_cnt[k] = 0;
          end else begin
            m_cnt[k] = m_cnt[k] + 1;
          end
        end
      end
    end
  endtask

  // Feed n bits, oldest first, taken from seq[n-1] down to seq[0].
  task automatic feed(input int n, input logic [15:0] seq, input bit ovl);
    for (int i = n - 1; i >= 0; i--) step(1'b1, seq[i], ovl, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic ctl(input bit ld, input bit cl, input logic [W-1:0] pi, input logic [W-1:0] mi);
    step(1'b0, 1'b0, 1'b0, ld, cl, 1'b0, pi, mi);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    model_reset();

    // Overlapping detection: matches on bits 4 and 7.
    feed(7, 16'b1011011, 1'b1);
    #1 check_value("ovl_cnt", 32'(hc0), 32'd2);

    // Non-overlapping detection.
    ctl(1'b0, 1'b1, '0, '0);
    feed(7, 16'b1011011, 1'b0);
    #1 check_value("novl_cnt_a", 32'(hc0), 32'd1);
    feed(6, 16'b011011, 1'b0);
    #1 check_value("novl_cnt_b", 32'(hc0), 32'd2);

    // Masked pattern 1xx1.
    ctl(1'b1, 1'b1, 4'b1001, 4'b1001);
    feed(5, 16'b11111, 1'b1);
    #1 check_value("mask_cnt", 32'(hc0), 32'd2);
    ctl(1'b0, 1'b1, '0, '0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    end
    #1 check_value("gap_cnt", 32'(hc0), 32'd2);

    // All-don't-care mask: 5 matches wrap or saturate the 2-bit counters.
    ctl(1'b1, 1'b1, 4'b0000, 4'b0000);
    feed(8, 16'hA5, 1'b1);
    #1;
    check_value("mask0_cnt", 32'(hc0), 32'd5);
    check_value("wrap_cnt", 32'(hc1), 32'd1);
    check_value("wrap_ovf", 32'(ov[1]), 32'd1);
    check_value("sat_cnt", 32'(hc2), 32'd3);
    check_value("sat_ovf", 32'(ov[2]), 32'd1);

    // Clear mid-stream with en high: that bit is ignored.
    ctl(1'b1, 1'b1, 4'b1011, 4'b1111);
    feed(3, 16'b101, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, '0, '0);
    feed(4, 16'b1011, 1'b1);
    #1 check_value("clr_mid_cnt", 32'(hc0), 32'd1);

    // Load mid-stream: new pattern, counter retained.
    feed(3, 16'b101, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0110, 4'b1111);
    feed(4, 16'b0110, 1'b1);
    #1 check_value("ld_mid_cnt", 32'(hc0), 32'd2);

    // Reset with en=1 and a bit that would complete a match.
    feed(3, 16'b011, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, '0, '0);
    #1;
    check_value("rst_cnt", 32'(hc0), 32'd0);
    check_value("rst_moore", 32'(yo[0]), 32'd0);
    check_value("rst_ovf", 32'(ov[0]), 32'd0);
    feed(4, 16'b1011, 1'b1);
    #1 check_value("rst_pat_cnt", 32'(hc0), 32'd1);

    // Randomised phase.
    for (int i = 0; i < 1500; i++) begin
      bit e, b, o, ld, cl, rs;
      logic [W-1:0] pi, mi;
      e  = ($urandom_range(0, 9) < 7);
      b  = 1'($urandom);
      o  = 1'($urandom);
      ld = ($urandom_range(0, 99) < 3);
      cl = ($urandom_range(0, 99) < 2);
      rs = ($urandom_range(0, 199) < 1);
      pi = W'($urandom);
      mi = W'($urandom) | W'($urandom);   // bias toward compared bits
      step(e, b, o, ld, cl, rs, pi, mi);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
